// File: rtl/decode_ctrl.sv
// Decode-stage control: instruction decode, load-use stall
// and illegal-opcode trap feeding the ID/EX register.
module decode_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic        validD,
  input  logic        flushE,
  output logic [1:0]  immsrcD,
  output logic [24:0] immD,
  output logic        stallF,
  output logic        stallD,
  output logic        validE,
  output logic        regwriteE,
  output logic [1:0]  resultsrcE,
  output logic        memwriteE,
  output logic        branchE,
  output logic        jumpE,
  output logic        alusrcE,
  output logic [1:0]  aluopE,
  output logic [2:0]  funct3E,
  output logic        funct7b5E,
  output logic [4:0]  rs1E,
  output logic [4:0]  rs2E,
  output logic [4:0]  rdE,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic       v;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } idex_t;

  state_t     state_q, state_d;
  idex_t      idex_q, idex_d;
  idex_t      dec;
  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic [6:0] op;

  assign op   = instrD[6:0];
  assign immD = instrD[31:7];

  // Opcode decode into control bundle, format and source usage
  always_comb begin
    dec          = '0;
    dec.v        = 1'b1;
    dec.funct3   = instrD[14:12];
    dec.funct7b5 = instrD[30];
    dec.rs1      = instrD[19:15];
    dec.rs2      = instrD[24:20];
    dec.rd       = instrD[11:7];
    immsrcD      = 2'b00;
    legal        = 1'b1;
    use_rs1      = 1'b1;
    use_rs2      = 1'b0;
    unique case (op)
      7'b0000011: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b01;
        dec.alusrc    = 1'b1;
      end
      7'b0100011: begin
        immsrcD      = 2'b10;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        use_rs2      = 1'b1;
      end
      7'b0110011: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
        use_rs2      = 1'b1;
      end
      7'b0010011: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b10;
      end
      7'b1100011: begin
        immsrcD    = 2'b01;
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
        use_rs2    = 1'b1;
      end
      7'b1101111: begin
        immsrcD       = 2'b11;
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = 2'b10;
        use_rs1       = 1'b0;
      end
      7'b1100111: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = 2'b10;
        dec.alusrc    = 1'b1;
      end
      default: begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
      end
    endcase
  end

  // Load in execute whose destination feeds a used source here
  always_comb begin
    hazard = idex_q.v && (idex_q.resultsrc == 2'b01) &&
             (idex_q.rd != 5'd0) && validD &&
             ((use_rs1 && (dec.rs1 == idex_q.rd)) ||
              (use_rs2 && (dec.rs2 == idex_q.rd)));
    stallF = (state_q == HALT) || (!flushE && hazard);
    stallD = stallF;
  end

  // Next state and ID/EX contents; anything but a clean issue is a bubble
  always_comb begin
    state_d = state_q;
    idex_d  = '0;
    if (state_q == RUN) begin
      if (flushE || hazard || !validD) begin
        idex_d = '0;
      end else if (!legal) begin
        state_d = HALT;
      end else begin
        idex_d = dec;
      end
    end
  end

  // FSM state and ID/EX register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign halted     = (state_q == HALT);
  assign validE     = idex_q.v;
  assign regwriteE  = idex_q.regwrite;
  assign resultsrcE = idex_q.resultsrc;
  assign memwriteE  = idex_q.memwrite;
  assign branchE    = idex_q.branch;
  assign jumpE      = idex_q.jump;
  assign alusrcE    = idex_q.alusrc;
  assign aluopE     = idex_q.aluop;
  assign funct3E    = idex_q.funct3;
  assign funct7b5E  = idex_q.funct7b5;
  assign rs1E       = idex_q.rs1;
  assign rs2E       = idex_q.rs2;
  assign rdE        = idex_q.rd;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl with an expected-result queue
// checked one cycle after each stimulus step.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrD;
  logic        validD;
  logic        flushE;
  logic [1:0]  immsrcD;
  logic [24:0] immD;
  logic        stallF, stallD;
  logic        validE, regwriteE, memwriteE, branchE, jumpE, alusrcE;
  logic [1:0]  resultsrcE, aluopE;
  logic [2:0]  funct3E;
  logic        funct7b5E;
  logic [4:0]  rs1E, rs2E, rdE;
  logic        halted;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       br;
    logic       jp;
    logic       as;
    logic [1:0] ao;
    logic [4:0] rd;
    logic       h;
  } exp_t;

  exp_t q[$];

  localparam logic [31:0] LW5  = 32'h0002A283;
  localparam logic [31:0] LW0  = 32'h0002A003;
  localparam logic [31:0] ADD  = 32'h00728333;
  localparam logic [31:0] ADDI = 32'h00538313;
  localparam logic [31:0] SW   = 32'h00512023;
  localparam logic [31:0] JAL  = 32'h000000EF;
  localparam logic [31:0] ILL  = 32'h0000007F;

  localparam exp_t BUB  = '0;
  localparam exp_t BUBH = 14'h0001;
  localparam exp_t E_LW5  = {1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,5'd5,1'b0};
  localparam exp_t E_LW0  = {1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,5'd0,1'b0};
  localparam exp_t E_ADD  = {1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,2'b10,5'd6,1'b0};
  localparam exp_t E_ADDI = {1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,5'd6,1'b0};
  localparam exp_t E_SW   = {1'b1,1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,2'b00,5'd0,1'b0};
  localparam exp_t E_JAL  = {1'b1,1'b1,2'b10,1'b0,1'b0,1'b1,1'b0,2'b00,5'd1,1'b0};

  decode_ctrl dut (
    .clk(clk), .reset(reset), .instrD(instrD), .validD(validD),
    .flushE(flushE), .immsrcD(immsrcD), .immD(immD),
    .stallF(stallF), .stallD(stallD), .validE(validE),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE),
    .memwriteE(memwriteE), .branchE(branchE), .jumpE(jumpE),
    .alusrcE(alusrcE), .aluopE(aluopE), .funct3E(funct3E),
    .funct7b5E(funct7b5E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {validE, regwriteE, resultsrcE, memwriteE, branchE,
            jumpE, alusrcE, aluopE, rdE, halted};
  endfunction

  task automatic chk_stall(input string tag, input logic exp);
    checks++;
    assert ({stallF, stallD} === {exp, exp}) else begin
      failures++;
      $error("FAIL %s stall obs=%b%b exp=%b", tag, stallF, stallD, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t exp);
    checks++;
    assert (observed() === exp) else begin
      failures++;
      $error("FAIL %s estate obs=%h exp=%h", tag, observed(), exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins,
                      input logic vd, input logic fl,
                      input logic exp_stall, input logic [1:0] exp_imm,
                      input exp_t e);
    exp_t want;
    @(negedge clk);
    instrD = ins;
    validD = vd;
    flushE = fl;
    #1;
    chk_stall(tag, exp_stall);
    checks++;
    assert (immsrcD === exp_imm) else begin
      failures++;
      $error("FAIL %s immsrc obs=%b exp=%b", tag, immsrcD, exp_imm);
    end
    checks++;
    assert (immD === ins[31:7]) else begin
      failures++;
      $error("FAIL %s immD obs=%h exp=%h", tag, immD, ins[31:7]);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    want = q.pop_front();
    chk_state(tag, want);
  endtask

  initial begin
    reset  = 1'b1;
    instrD = ADD;
    validD = 1'b1;
    flushE = 1'b0;
    #1;
    chk_state("reset_async", BUB);
    chk_stall("reset_async", 1'b0);
    @(posedge clk);
    #1;
    chk_state("reset_edge", BUB);
    @(negedge clk);
    reset = 1'b0;

    step("lw5",        LW5,  1, 0, 0, 2'b00, E_LW5);
    step("lu_stall",   ADD,  1, 0, 1, 2'b00, BUB);
    step("lu_release", ADD,  1, 0, 0, 2'b00, E_ADD);
    step("lw0",        LW0,  1, 0, 0, 2'b00, E_LW0);
    step("rd0_nostall",ADD,  1, 0, 0, 2'b00, E_ADD);
    step("lw5b",       LW5,  1, 0, 0, 2'b00, E_LW5);
    step("addi_rs2",   ADDI, 1, 0, 0, 2'b00, E_ADDI);
    step("sw_flush",   SW,   1, 1, 0, 2'b10, BUB);
    step("sw",         SW,   1, 0, 0, 2'b10, E_SW);
    step("jal",        JAL,  1, 0, 0, 2'b11, E_JAL);
    step("ill_flush",  ILL,  1, 1, 0, 2'b00, BUB);
    step("invalid",    ADD,  0, 0, 0, 2'b00, BUB);
    step("lw5c",       LW5,  1, 0, 0, 2'b00, E_LW5);
    step("lu_flush",   ADD,  1, 1, 0, 2'b00, BUB);
    step("lw5d",       LW5,  1, 0, 0, 2'b00, E_LW5);
    step("trap",       ILL,  1, 0, 0, 2'b00, BUBH);
    for (int i = 0; i < 12; i++)
      step("halt_hold", ADD, 1, 0, 1, 2'b00, BUBH);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_state("halt_reset", BUB);
    chk_stall("halt_reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("post_halt",  ADD,  1, 0, 0, 2'b00, E_ADD);

    step("lw5e",       LW5,  1, 0, 0, 2'b00, E_LW5);
    @(negedge clk);
    instrD = ADD;
    validD = 1'b1;
    flushE = 1'b0;
    #1;
    chk_stall("mid_stall", 1'b1);
    reset = 1'b1;
    #1;
    chk_stall("stall_reset", 1'b0);
    chk_state("stall_reset", BUB);
    @(negedge clk);
    reset = 1'b0;
    step("post_stall", ADD,  1, 0, 0, 2'b00, E_ADD);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL queue_empty obs=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
